// File: rtl/vstore_if.sv
// vstore_if: request, flush and dOutMem write-port bundle for the vector-store sequencer
interface vstore_if #(
  parameter int WIDTH = 24,
  parameter int LANES = 4
);
  localparam int CW = $clog2(LANES + 1);
  logic                   req_valid;
  logic                   req_ready;
  logic [WIDTH-1:0]       req_base;
  logic [WIDTH-1:0]       req_stride;
  logic [CW-1:0]          req_count;
  logic [LANES*WIDTH-1:0] req_data;
  logic                   flush_req;
  logic                   we;
  logic [WIDTH-1:0]       address;
  logic [WIDTH-1:0]       wd;
  logic                   startIO;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [WIDTH-1:0]       wr_total;
  modport master (
    output req_valid, req_base, req_stride, req_count, req_data, flush_req,
    input  req_ready, we, address, wd, startIO, busy, done, err, wr_total
  );
  modport slave (
    input  req_valid, req_base, req_stride, req_count, req_data, flush_req,
    output req_ready, we, address, wd, startIO, busy, done, err, wr_total
  );
endinterface

// File: rtl/vstore_seq.sv
// vstore_seq: serialises a packed vector store into per-cycle dOutMem writes and issues startIO dumps
module vstore_seq #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 10000,
  parameter int LANES = 4
) (
  input logic     clk,
  input logic     rst,
  vstore_if.slave bus
);
  localparam int CW = $clog2(LANES + 1);
  typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;
  state_t                 state, state_n;
  logic [CW-1:0]          cnt, idx, cnt_in;
  logic [WIDTH-1:0]       stride, addr_q, wd_q, total;
  logic [LANES*WIDTH-1:0] data_q;
  logic                   err_q, in_range, last, accept;
  assign cnt_in   = bus.req_count > CW'(LANES) ? CW'(LANES) : bus.req_count;
  assign in_range = addr_q < WIDTH'(DEPTH);
  assign last     = idx == cnt - CW'(1);
  assign accept   = state == IDLE && bus.req_valid && cnt_in != '0;
  assign bus.address  = addr_q;
  assign bus.wd       = wd_q;
  assign bus.err      = err_q;
  assign bus.wr_total = total;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state and state-decoded outputs; a request outranks a pending flush
  always_comb begin
    state_n       = IDLE;
    bus.req_ready = state == IDLE;
    bus.we        = state == WRITE && in_range;
    bus.done      = state == WRITE && last;
    bus.startIO   = state == FLUSH;
    bus.busy      = state != IDLE;
    if (state == IDLE)
      state_n = bus.req_valid ? (cnt_in != '0 ? WRITE : IDLE) : (bus.flush_req ? FLUSH : IDLE);
    else if (state == WRITE)
      state_n = last ? IDLE : WRITE;
  end
  // element datapath: the data shift register presents the next lane in wd_q each cycle,
  // and address/wd are left untouched after the last element so they hold outside WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wd_q   <= '0;
      data_q <= '0;
      stride <= '0;
      cnt    <= '0;
      idx    <= '0;
      err_q  <= 1'b0;
      total  <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.req_base;
        wd_q   <= bus.req_data[WIDTH-1:0];
        data_q <= bus.req_data >> WIDTH;
        stride <= bus.req_stride;
        cnt    <= cnt_in;
        idx    <= '0;
      end
      if (state == WRITE) begin
        idx   <= idx + CW'(1);
        total <= total + {{(WIDTH-1){1'b0}}, in_range};
        err_q <= err_q | ~in_range;
        if (!last) begin
          addr_q <= addr_q + stride;
          wd_q   <= data_q[WIDTH-1:0];
          data_q <= data_q >> WIDTH;
        end
      end
    end
  end
endmodule

// File: tb/tb_vstore_seq.sv
// tb_vstore_seq: directed checks of store serialisation, range drops, flush ordering and reset
module tb_vstore_seq;
  localparam int WIDTH = 24;
  localparam int DEPTH = 10000;
  localparam int LANES = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  vstore_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();
  vstore_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [23:0] base, input logic [23:0] stride, input logic [2:0] count,
                       input logic [95:0] data, input logic flush);
    bus.req_valid  = 1'b1;
    bus.req_base   = base;
    bus.req_stride = stride;
    bus.req_count  = count;
    bus.req_data   = data;
    bus.flush_req  = flush;
    step();
    bus.req_valid = 1'b0;
  endtask
  task automatic elem(input string tag, input logic [23:0] a, input logic w, input logic [23:0] d, input logic dn);
    check({tag, "_we"}, bus.we, w);
    check({tag, "_addr"}, bus.address, a);
    check({tag, "_wd"}, bus.wd, d);
    check({tag, "_done"}, bus.done, dn);
    check({tag, "_ready"}, bus.req_ready, 1'b0);
    step();
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_base = '0; bus.req_stride = '0;
    bus.req_count = '0; bus.req_data = '0; bus.flush_req = 1'b0;
    step(); step();
    check("rst_we", bus.we, 1'b0);
    check("rst_addr", bus.address, 24'h0);
    check("rst_wd", bus.wd, 24'h0);
    check("rst_startIO", bus.startIO, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_total", bus.wr_total, 24'h0);
    rst = 1'b0;
    step();
    check("idle_ready", bus.req_ready, 1'b1);
    issue(24'd0, 24'd1, 3'd3, {24'h0, 24'h778899, 24'h445566, 24'h112233}, 1'b0);
    elem("t1e0", 24'd0, 1'b1, 24'h112233, 1'b0);
    elem("t1e1", 24'd1, 1'b1, 24'h445566, 1'b0);
    elem("t1e2", 24'd2, 1'b1, 24'h778899, 1'b1);
    check("t1_we_after", bus.we, 1'b0);
    check("t1_done_after", bus.done, 1'b0);
    check("t1_busy_after", bus.busy, 1'b0);
    check("t1_addr_hold", bus.address, 24'd2);
    check("t1_total", bus.wr_total, 24'd3);
    issue(24'd100, 24'd100, 3'd4, {24'hd4, 24'hc3, 24'hb2, 24'ha1}, 1'b0);
    elem("t2e0", 24'd100, 1'b1, 24'ha1, 1'b0);
    elem("t2e1", 24'd200, 1'b1, 24'hb2, 1'b0);
    elem("t2e2", 24'd300, 1'b1, 24'hc3, 1'b0);
    elem("t2e3", 24'd400, 1'b1, 24'hd4, 1'b1);
    check("t2_ready_after", bus.req_ready, 1'b1);
    check("t2_total", bus.wr_total, 24'd7);
    issue(24'd9998, 24'd1, 3'd4, {24'h4, 24'h3, 24'h2, 24'h1}, 1'b0);
    elem("t3e0", 24'd9998, 1'b1, 24'h1, 1'b0);
    check("t3_err_pre", bus.err, 1'b0);
    elem("t3e1", 24'd9999, 1'b1, 24'h2, 1'b0);
    elem("t3e2", 24'd10000, 1'b0, 24'h3, 1'b0);
    check("t3_err_set", bus.err, 1'b1);
    elem("t3e3", 24'd10001, 1'b0, 24'h4, 1'b1);
    step(); step();
    check("t3_err_held", bus.err, 1'b1);
    check("t3_total", bus.wr_total, 24'd9);
    issue(24'd0, 24'd1, 3'd2, {48'h0, 24'hbb, 24'haa}, 1'b0);
    bus.flush_req = 1'b1;
    check("t4_noio_w0", bus.startIO, 1'b0);
    elem("t4e0", 24'd0, 1'b1, 24'haa, 1'b0);
    check("t4_noio_w1", bus.startIO, 1'b0);
    elem("t4e1", 24'd1, 1'b1, 24'hbb, 1'b1);
    check("t4_noio_idle", bus.startIO, 1'b0);
    check("t4_idle_busy", bus.busy, 1'b0);
    step();
    check("t4_io", bus.startIO, 1'b1);
    check("t4_io_we", bus.we, 1'b0);
    check("t4_io_busy", bus.busy, 1'b1);
    bus.flush_req = 1'b0;
    step();
    check("t4_io_end", bus.startIO, 1'b0);
    check("t4_total", bus.wr_total, 24'd11);
    issue(24'd5, 24'd1, 3'd1, {72'h0, 24'hcc}, 1'b1);
    check("t4b_noio", bus.startIO, 1'b0);
    elem("t4be0", 24'd5, 1'b1, 24'hcc, 1'b1);
    check("t4b_noio_idle", bus.startIO, 1'b0);
    step();
    check("t4b_io", bus.startIO, 1'b1);
    bus.flush_req = 1'b0;
    step();
    check("t4b_io_end", bus.startIO, 1'b0);
    check("t4b_total", bus.wr_total, 24'd12);
    issue(24'hffffff, 24'd2, 3'd2, {48'h0, 24'h22, 24'h11}, 1'b0);
    elem("wr_e0", 24'hffffff, 1'b0, 24'h11, 1'b0);
    elem("wr_e1", 24'd1, 1'b1, 24'h22, 1'b1);
    check("wr_total", bus.wr_total, 24'd13);
    issue(24'd0, 24'd2, 3'd7, {24'h4, 24'h3, 24'h2, 24'h1}, 1'b0);
    elem("cl_e0", 24'd0, 1'b1, 24'h1, 1'b0);
    elem("cl_e1", 24'd2, 1'b1, 24'h2, 1'b0);
    elem("cl_e2", 24'd4, 1'b1, 24'h3, 1'b0);
    elem("cl_e3", 24'd6, 1'b1, 24'h4, 1'b1);
    check("cl_busy_after", bus.busy, 1'b0);
    check("cl_total", bus.wr_total, 24'd17);
    issue(24'd50, 24'd1, 3'd4, {24'h4, 24'h3, 24'h2, 24'h1}, 1'b0);
    elem("t5e0", 24'd50, 1'b1, 24'h1, 1'b0);
    check("t5e1_we", bus.we, 1'b1);
    check("t5e1_addr", bus.address, 24'd51);
    rst = 1'b1;
    step();
    check("t5_we", bus.we, 1'b0);
    check("t5_busy", bus.busy, 1'b0);
    check("t5_err", bus.err, 1'b0);
    check("t5_total", bus.wr_total, 24'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_quiet_we", bus.we, 1'b0);
      check("t5_quiet_busy", bus.busy, 1'b0);
    end
    check("t5_quiet_total", bus.wr_total, 24'd0);
    issue(24'd7, 24'd1, 3'd0, {4{24'h5a5a5a}}, 1'b0);
    check("t6_we", bus.we, 1'b0);
    check("t6_done", bus.done, 1'b0);
    check("t6_busy", bus.busy, 1'b0);
    check("t6_ready", bus.req_ready, 1'b1);
    step();
    check("t6_we2", bus.we, 1'b0);
    check("t6_total", bus.wr_total, 24'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
